pe_array_sequencer: RTL and testbench

- Sequences one pass of a ROWS x COLS systolic array of 8-bit-activation / 19-bit-partial-sum processing elements.
- Reads activation vectors from a synchronous buffer and applies diagonal input skew per row. Injects zero partial sums at the top edge.
- Deskews the bottom-row out_c results into one aligned result word per vector.
- Sits between the activation buffer / host control and the PE array. Start/busy/done handshake toward the host.

---
 rtl/pe_array_sequencer_pkg.sv | 20 ++
 rtl/pe_array_sequencer_skew_line.sv | 30 +++
 rtl/pe_array_sequencer.sv | 146 ++++++++++++++
 tb/tb_pe_array_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_sequencer_pkg.sv
// Shared constants and state encoding for the
// PE array sequencer.
package pe_array_sequencer_pkg;

  localparam int DWIDTH    = 8;
  localparam int PSUM_W    = 19;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ARR_LAT   = 4;
  localparam int DRAIN_CYC = ARR_LAT + COLS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/pe_array_sequencer_skew_line.sv
// Depth-N, width-W shift register with a
// synchronous clear, used for skew and deskew.
module pe_array_sequencer_skew_line #(
  parameter int N = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [N];

  // Shift one stage per cycle; clr empties the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences one pass of the systolic array:
// buffer reads, input skew, output deskew.
module pe_array_sequencer
  import pe_array_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [7:0]             num_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   act_rd_en,
  output logic [7:0]             act_rd_addr,
  input  logic [ROWS*DWIDTH-1:0] act_rd_data,
  output logic                   arr_clear,
  output logic [ROWS*DWIDTH-1:0] arr_in_a,
  output logic [COLS*PSUM_W-1:0] arr_in_b,
  input  logic [COLS*DWIDTH-1:0] arr_out_c,
  output logic                   res_valid,
  output logic [COLS*DWIDTH-1:0] res_data
);

  localparam logic [7:0] DRAIN_LAST =
    8'(DRAIN_CYC - 1);

  state_t                 state, nxt;
  logic [7:0]             cnt, nv;
  logic [DRAIN_CYC-1:0]   vld;
  logic [ROWS*DWIDTH-1:0] a_gated;
  logic [COLS*DWIDTH-1:0] aligned, hold;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; abort overrides all
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (start)
          nxt = (num_vec != 8'd0) ? S_CLEAR
                                  : S_DONE;
      S_CLEAR: nxt = S_FEED;
      S_FEED:
        if (cnt == nv - 8'd1) nxt = S_DRAIN;
      S_DRAIN:
        if (cnt == DRAIN_LAST) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  // Vector / drain counter and latched length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      nv  <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) nv <= num_vec;
        end
        S_FEED:
          cnt <= (cnt == nv - 8'd1) ? 8'd0
                                    : cnt + 8'd1;
        S_DRAIN: cnt <= cnt + 8'd1;
        default: cnt <= '0;
      endcase
    end
  end

  assign busy      = (state == S_CLEAR) ||
                     (state == S_FEED)  ||
                     (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign arr_clear = (state == S_CLEAR);
  assign act_rd_en = (state == S_FEED);
  assign act_rd_addr =
    act_rd_en ? cnt : 8'd0;
  assign arr_in_b  = '0;

  // Valid chain: bit k marks a read k+1 cycles ago
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     vld <= '0;
    else if (abort) vld <= '0;
    else
      vld <= {vld[DRAIN_CYC-2:0], act_rd_en};
  end

  assign a_gated = vld[0] ? act_rd_data : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_pass
      assign arr_in_a[DWIDTH-1:0] =
        a_gated[DWIDTH-1:0];
    end else begin : g_dly
      pe_array_sequencer_skew_line #(
        .N (r),
        .W (DWIDTH)
      ) u_skew (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .d     (a_gated[r*DWIDTH +: DWIDTH]),
        .q     (arr_in_a[r*DWIDTH +: DWIDTH])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_pass
      assign aligned[c*DWIDTH +: DWIDTH] =
        arr_out_c[c*DWIDTH +: DWIDTH];
    end else begin : g_dly
      pe_array_sequencer_skew_line #(
        .N (COLS - 1 - c),
        .W (DWIDTH)
      ) u_deskew (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .d     (arr_out_c[c*DWIDTH +: DWIDTH]),
        .q     (aligned[c*DWIDTH +: DWIDTH])
      );
    end
  end

  assign res_valid = vld[DRAIN_CYC-1];

  // Keep the last result visible between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         hold <= '0;
    else if (res_valid) hold <= aligned;
  end

  assign res_data = res_valid ? aligned : hold;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench: timeline reference model,
// behavioural buffer and weighted-sum array model.
module tb_pe_array_sequencer;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ARR_LAT   = 4;
  localparam int DRAIN_CYC = ARR_LAT + COLS;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  num_vec;
  logic        busy, done, act_rd_en;
  logic [7:0]  act_rd_addr;
  logic [31:0] act_rd_data = '0;
  logic        arr_clear;
  logic [31:0] arr_in_a;
  logic [75:0] arr_in_b;
  logic [31:0] arr_out_c = '0;
  logic        res_valid;
  logic [31:0] res_data;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] mem  [256];
  logic [31:0] hist [4096];
  logic [7:0]  w    [ROWS][COLS];
  logic [31:0] last_res;
  logic        rd_s = 1'b0;
  logic [7:0]  addr_s = '0;

  pe_array_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_vec     (num_vec),
    .busy        (busy),
    .done        (done),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .act_rd_data (act_rd_data),
    .arr_clear   (arr_clear),
    .arr_in_a    (arr_in_a),
    .arr_in_b    (arr_in_b),
    .arr_out_c   (arr_out_c),
    .res_valid   (res_valid),
    .res_data    (res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [31:0] a
  );
    logic [31:0] o;
    logic [7:0]  acc;
    o = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = '0;
      for (int r = 0; r < ROWS; r++)
        acc = acc + a[r*8 +: 8] * w[r][c];
      o[c*8 +: 8] = acc;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    rd_s   = act_rd_en;
    addr_s = act_rd_addr;
    hist[cyc % 4096] = arr_in_a;
  end

  always @(posedge clk) begin
    int t0;
    logic [31:0] v, m;
    #1;
    cyc++;
    act_rd_data = rd_s ? mem[addr_s] : $urandom();
    for (int c = 0; c < COLS; c++) begin
      v  = '0;
      t0 = cyc - ARR_LAT - c;
      for (int r = 0; r < ROWS; r++)
        if (t0 + r >= 0)
          v[r*8 +: 8] =
            hist[(t0 + r) % 4096][r*8 +: 8];
      m = model(v);
      arr_out_c[c*8 +: 8] = m[c*8 +: 8];
    end
  end

  task automatic chk(
    input string        tag,
    input int           k,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %0h expected %0h",
             tag, k, obs, exp);
    end
  endtask

  task automatic run_pass(
    input int n,
    input int ab,
    input bit hold,
    input bit fixed
  );
    int          kd, t, j, vv;
    bit          alive, ev, act;
    logic [31:0] ea, ed;
    logic [31:0] expv [256];
    if (!fixed)
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
    for (int i = 0; i < 256; i++) expv[i] = model(mem[i]);
    kd = (n == 0) ? 1 : n + DRAIN_CYC + 2;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 8'(n);
    for (int k = 1; k <= kd + 2; k++) begin
      @(negedge clk);
      t     = k - 2;
      alive = !(ab >= 0 && k > ab + 2);
      act   = alive && (n > 0);
      chk("arr_clear", k, arr_clear, act && k == 1);
      chk("act_rd_en", k, act_rd_en,
          act && t >= 0 && t < n);
      chk("act_rd_addr", k, act_rd_addr,
          (act && t >= 0 && t < n) ? t : 0);
      chk("busy", k, busy,
          act && k >= 1 && t < n + DRAIN_CYC);
      chk("done", k, done, alive && k == kd);
      chk("arr_in_b", k, arr_in_b, 0);
      ea = '0;
      for (int r = 0; r < ROWS; r++) begin
        vv = t - 1 - r;
        if (act && vv >= 0 && vv < n)
          ea[r*8 +: 8] = mem[vv][r*8 +: 8];
      end
      chk("arr_in_a", k, arr_in_a, ea);
      j  = t - ARR_LAT - COLS;
      ev = act && j >= 0 && j < n;
      ed = ev ? expv[j] : last_res;
      chk("res_valid", k, res_valid, ev);
      chk("res_data", k, res_data, ed);
      if (ev) last_res = expv[j];
      start = 1'b0;
      abort = 1'b0;
      if (hold && k <= kd) start = 1'b1;
      if (ab >= 0 && k == ab + 2) begin
        start = 1'b1;
        abort = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    num_vec  = '0;
    last_res = '0;
    for (int i = 0; i < 4096; i++) hist[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        w[r][c] = 8'($urandom_range(1, 255));
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_rd_en", 0, act_rd_en, 0);
    chk("rst_clear", 0, arr_clear, 0);
    chk("rst_valid", 0, res_valid, 0);
    chk("rst_addr", 0, act_rd_addr, 0);
    chk("rst_in_a", 0, arr_in_a, 0);
    chk("rst_res", 0, res_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    run_pass(1, -1, 1'b0, 1'b1);
    run_pass(5, -1, 1'b0, 1'b0);
    run_pass(0, -1, 1'b0, 1'b0);
    run_pass(10, 2, 1'b0, 1'b0);
    run_pass(3, -1, 1'b1, 1'b0);
    run_pass(2, -1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++)
      run_pass($urandom_range(1, 20), -1, 1'b0, 1'b0);
    run_pass(255, -1, 1'b0, 1'b0);

    @(negedge clk);
    start   = 1'b1;
    num_vec = 8'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_busy", 0, busy, 0);
    chk("mid_done", 0, done, 0);
    chk("mid_rd_en", 0, act_rd_en, 0);
    chk("mid_clear", 0, arr_clear, 0);
    chk("mid_valid", 0, res_valid, 0);
    chk("mid_addr", 0, act_rd_addr, 0);
    chk("mid_in_a", 0, arr_in_a, 0);
    chk("mid_res", 0, res_data, 0);
    last_res = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("post_busy", k, busy, 0);
      chk("post_done", k, done, 0);
      chk("post_rd_en", k, act_rd_en, 0);
      chk("post_valid", k, res_valid, 0);
    end
    run_pass(4, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
